// File: rtl/sr_cmd_conditioner_if.sv
// Request/command bundle between the raw request
// sources and the SR command conditioner.
interface sr_cmd_conditioner_if;
  logic set_req_raw;
  logic rst_req_raw;
  logic s;
  logic r;
  logic busy;
  logic conflict;

  modport master (
    output set_req_raw,
    output rst_req_raw,
    input  s,
    input  r,
    input  busy,
    input  conflict
  );

  modport slave (
    input  set_req_raw,
    input  rst_req_raw,
    output s,
    output r,
    output busy,
    output conflict
  );
endinterface

// File: rtl/sr_cmd_conditioner.sv
// Synchronize, debounce and edge-detect two raw request
// lines; arbitrate them into exclusive s/r command pulses.
module sr_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter bit PRIORITY_RESET  = 1'b1,
  parameter int CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sr_cmd_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HO_LAST =
    CNT_W'(HOLDOFF_CYCLES > 0 ? HOLDOFF_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  // channel 0 = set, channel 1 = reset
  logic [1:0]       w_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_prime;
  logic [1:0]       r_deb;
  logic [1:0]       r_arm;
  logic [1:0]       r_pend;
  logic [CNT_W-1:0] r_cnt [2];

  logic [1:0]       w_lvl;
  logic [1:0]       w_diff;
  logic [1:0]       w_full;
  logic [1:0]       w_rise;
  logic [1:0]       w_clr;
  logic             w_primed;
  logic             w_both;
  logic             w_pick_r;

  state_t           r_state;
  logic [CNT_W-1:0] r_hcnt;
  logic             r_s;
  logic             r_r;
  logic             r_busy;
  logic             r_conflict;

  assign w_raw = {bus.rst_req_raw, bus.set_req_raw};

  // Until a channel has seen a genuine debounced low after
  // reset it compares against a virtual high level, so a line
  // held high through reset never produces a rising edge.
  always_comb begin
    w_primed = r_prime[1];
    for (int i = 0; i < 2; i++) begin
      w_lvl[i]  = r_arm[i] ? r_deb[i] : 1'b1;
      w_diff[i] = w_primed && (r_sync2[i] != w_lvl[i]);
      w_full[i] = (r_cnt[i] + ONE) == DEB_N;
      w_rise[i] = w_diff[i] && w_full[i]
                  && r_arm[i] && !r_deb[i];
    end
  end

  // Arbitration: IDLE consumes every pending flag it sees,
  // the loser of a simultaneous pair is simply dropped.
  always_comb begin
    w_both   = r_pend[0] & r_pend[1];
    w_pick_r = r_pend[1] & (~r_pend[0] | PRIORITY_RESET);
    w_clr    = (r_state == IDLE) ? r_pend : 2'b00;
  end

  // Synchronizers, debounce counters and one-deep pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prime  <= '0;
      r_deb    <= '0;
      r_arm    <= '0;
      r_pend   <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prime <= {r_prime[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        if (!w_diff[i]) begin
          r_cnt[i] <= '0;
        end else if (w_full[i]) begin
          r_cnt[i] <= '0;
          if (r_arm[i]) begin
            r_deb[i] <= ~r_deb[i];
          end else begin
            r_arm[i] <= 1'b1;
          end
        end else begin
          r_cnt[i] <= r_cnt[i] + ONE;
        end
        r_pend[i] <= r_pend[i] ? ~w_clr[i] : w_rise[i];
      end
    end
  end

  // Command FSM with registered s/r/busy/conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hcnt     <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|r_pend) begin
            r_state    <= ISSUE;
            r_s        <= ~w_pick_r;
            r_r        <= w_pick_r;
            r_busy     <= 1'b1;
            r_conflict <= w_both;
          end
        end
        ISSUE: begin
          r_s        <= 1'b0;
          r_r        <= 1'b0;
          r_conflict <= 1'b0;
          r_hcnt     <= '0;
          if (HOLDOFF_CYCLES == 0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_hcnt == HO_LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_hcnt  <= '0;
          end else begin
            r_hcnt <= r_hcnt + ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s        = r_s;
  assign bus.r        = r_r;
  assign bus.busy     = r_busy;
  assign bus.conflict = r_conflict;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner: two instances that
// differ only in arbitration priority share the same stimulus.
module tb_sr_cmd_conditioner;

  logic clk;
  logic rst_n;
  logic set_raw;
  logic rst_raw;
  int   cyc;
  int   n_chk;
  int   n_pass;

  sr_cmd_conditioner_if bus0 ();
  sr_cmd_conditioner_if bus1 ();

  assign bus0.set_req_raw = set_raw;
  assign bus0.rst_req_raw = rst_raw;
  assign bus1.set_req_raw = set_raw;
  assign bus1.rst_req_raw = rst_raw;

  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (2),
    .PRIORITY_RESET (1'b1),
    .CNT_W          (8)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (2),
    .PRIORITY_RESET (1'b0),
    .CNT_W          (8)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] w_s;
  logic [1:0] w_r;
  logic [1:0] w_b;
  logic [1:0] w_c;
  assign w_s = {bus1.s, bus0.s};
  assign w_r = {bus1.r, bus0.r};
  assign w_b = {bus1.busy, bus0.busy};
  assign w_c = {bus1.conflict, bus0.conflict};

  int n_s   [2] = '{0, 0};
  int n_r   [2] = '{0, 0};
  int n_c   [2] = '{0, 0};
  int n_b   [2] = '{0, 0};
  int n_ovl [2] = '{0, 0};
  int n_wide[2] = '{0, 0};
  int n_near[2] = '{0, 0};
  int last_s[2] = '{-100, -100};
  int last_r[2] = '{-100, -100};
  int last_c[2] = '{-100, -100};
  int last_p[2] = '{-100, -100};
  bit prev_p[2] = '{1'b0, 1'b0};

  // Observe outputs mid-cycle: after edge E, cyc == E.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < 2; j++) begin
        if (w_s[j] & w_r[j]) n_ovl[j]++;
        if (w_s[j]) begin
          n_s[j]++;
          last_s[j] = cyc;
        end
        if (w_r[j]) begin
          n_r[j]++;
          last_r[j] = cyc;
        end
        if (w_c[j]) begin
          n_c[j]++;
          last_c[j] = cyc;
        end
        if (w_b[j]) n_b[j]++;
        if (w_s[j] | w_r[j]) begin
          if (prev_p[j]) n_wide[j]++;
          else if (cyc - last_p[j] < 4) n_near[j]++;
          if (!prev_p[j]) last_p[j] = cyc;
        end
        prev_p[j] = w_s[j] | w_r[j];
      end
    end else begin
      prev_p[0] = 1'b0;
      prev_p[1] = 1'b0;
    end
  end

  int b_s[2];
  int b_r[2];
  int b_c[2];
  int b_b[2];

  task automatic snap();
    for (int j = 0; j < 2; j++) begin
      b_s[j] = n_s[j];
      b_r[j] = n_r[j];
      b_c[j] = n_c[j];
      b_b[j] = n_b[j];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  int p;

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    set_raw = 1'b0;
    rst_raw = 1'b0;
    rst_n   = 1'b0;
    tick(3);
    chk("rst_out0", {bus0.s, bus0.r, bus0.busy,
                     bus0.conflict}, 0);
    chk("rst_out1", {bus1.s, bus1.r, bus1.busy,
                     bus1.conflict}, 0);
    rst_n = 1'b1;
    tick(12);

    // clean set press
    snap();
    p = cyc;
    set_raw = 1'b1;
    tick(20);
    set_raw = 1'b0;
    tick(12);
    chk("t1_ns",   n_s[0] - b_s[0], 1);
    chk("t1_when", last_s[0], p + 7);
    chk("t1_nr",   n_r[0] - b_r[0], 0);
    chk("t1_busy", n_b[0] - b_b[0], 3);
    chk("t1_ns1",  n_s[1] - b_s[1], 1);

    // glitch shorter than the debounce window
    snap();
    p = cyc;
    set_raw = 1'b1;
    tick(3);
    set_raw = 1'b0;
    tick(2);
    chk("t2_cnt3", int'(u_dut0.r_cnt[0]), 3);
    tick(10);
    chk("t2_cnt0", int'(u_dut0.r_cnt[0]), 0);
    chk("t2_ns",   n_s[0] - b_s[0], 0);
    chk("t2_busy", n_b[0] - b_b[0], 0);

    // simultaneous requests
    snap();
    p = cyc;
    set_raw = 1'b1;
    rst_raw = 1'b1;
    tick(15);
    set_raw = 1'b0;
    rst_raw = 1'b0;
    tick(12);
    chk("t3_nr0",  n_r[0] - b_r[0], 1);
    chk("t3_ns0",  n_s[0] - b_s[0], 0);
    chk("t3_nc0",  n_c[0] - b_c[0], 1);
    chk("t3_r0at", last_r[0], p + 7);
    chk("t3_c0at", last_c[0], p + 7);
    chk("t3_ns1",  n_s[1] - b_s[1], 1);
    chk("t3_nr1",  n_r[1] - b_r[1], 0);
    chk("t3_nc1",  n_c[1] - b_c[1], 1);
    chk("t3_c1at", last_c[1], p + 7);

    // reset request lands during the set hold-off
    snap();
    p = cyc;
    set_raw = 1'b1;
    tick(3);
    rst_raw = 1'b1;
    tick(20);
    set_raw = 1'b0;
    rst_raw = 1'b0;
    tick(12);
    chk("t4_s_at", last_s[0], p + 7);
    chk("t4_r_at", last_r[0], p + 11);
    chk("t4_nc",   n_c[0] - b_c[0], 0);
    chk("t4_busy", n_b[0] - b_b[0], 6);

    // async reset during the ISSUE cycle
    p = cyc;
    set_raw = 1'b1;
    rst_raw = 1'b1;
    tick(7);
    chk("t5_s_hi", int'(bus1.s), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_s_lo", {bus1.s, bus1.busy, bus0.r,
                    bus0.busy}, 0);
    tick(2);
    rst_n = 1'b1;
    snap();
    tick(20);
    chk("t5_held", n_s[0] + n_r[0] + n_s[1] + n_r[1]
                   - b_s[0] - b_r[0] - b_s[1] - b_r[1], 0);
    set_raw = 1'b0;
    rst_raw = 1'b0;
    tick(12);
    p = cyc;
    set_raw = 1'b1;
    tick(12);
    set_raw = 1'b0;
    tick(12);
    chk("t5_ns",   n_s[0] - b_s[0], 1);
    chk("t5_s_at", last_s[0], p + 7);

    // random bounce on both lines
    snap();
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) set_raw = ~set_raw;
      if ($urandom_range(7) == 0) rst_raw = ~rst_raw;
      tick(1);
    end
    set_raw = 1'b0;
    rst_raw = 1'b0;
    tick(20);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("t6_ovl%0d", j), n_ovl[j], 0);
      chk($sformatf("t6_wide%0d", j), n_wide[j], 0);
      chk($sformatf("t6_near%0d", j), n_near[j], 0);
      chk($sformatf("t6_some%0d", j),
          int'((n_s[j] - b_s[j]) + (n_r[j] - b_r[j]) > 0), 1);
      chk($sformatf("t6_busy%0d", j), n_b[j] - b_b[j],
          3 * ((n_s[j] - b_s[j]) + (n_r[j] - b_r[j])));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
